alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered pipeline stage directly downstream of the combinational Hack ALU datapath (the 16-bit bitwise And/Or/Not/Add network).
- Captures the 16-bit ALU result and its destination bits. Generates the zr/ng status flags from the captured value.
- Presents the result to write-back (A/D/M) through a valid/ready handshake.
- Contains a 2-entry skid buffer, so upstream sees a registered ready and no data is lost under backpressure.

Parameters:
- WIDTH, 16, datapath width; flags are defined for any WIDTH >= 2; the Hack build uses 16.
- DEST_W, 3, width of the destination field (Hack d1 d2 d3 = A, D, M).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset; asserting it clears all state immediately; deassertion is synchronous to clk.
- flush  input  1  synchronous clear of all buffered entries (jump taken / pipeline kill).
- in_valid  input  1  ALU result valid.
- in_ready  output  1  stage can accept; registered.
- in_data  input  WIDTH  ALU result.
- in_dest  input  DEST_W  destination bits for this result.
- out_valid  output  1  out_* fields hold a valid entry.
- out_ready  input  1  write-back consumes the entry.
- out_data  output  WIDTH  buffered result.
- out_dest  output  DEST_W  buffered destination.
- out_zr  output  1  1 when out_data == 0.
- out_ng  output  1  1 when out_data[WIDTH-1] == 1.
- out_count  output  16  number of entries delivered (out_valid & out_ready) since reset; wraps from 65535 to 0.

Behaviour:
- Accept = in_valid & in_ready & ~flush.
- Pop = out_valid & out_ready & ~flush.
- Internal storage is two entries, main and skid. Each entry holds data, dest, zr and ng.
- zr and ng are computed from in_data at capture: zr = NOR-reduction of all bits; ng = MSB. They are stored with the entry, never recomputed on the output side.
- States:
  - EMPTY (0 entries): in_ready = 1, out_valid = 0.
  - ONE (1 entry, in main): in_ready = 1, out_valid = 1.
  - TWO (main and skid full): in_ready = 0, out_valid = 1.
- Transitions, evaluated each rising edge:
  - EMPTY: Accept -> main <= in, go to ONE. Otherwise stay.
  - ONE: Accept & Pop -> main <= in, stay ONE. Accept & ~Pop -> skid <= in, go to TWO. ~Accept & Pop -> EMPTY. Neither -> stay.
  - TWO: Pop -> main <= skid, go to ONE. Otherwise stay. Accept is impossible because in_ready = 0.
- in_ready is a flop: it is 0 exactly when the next state is TWO. It must not depend combinationally on out_ready.
- Latency: data accepted at edge N appears on out_* after edge N, visible in cycle N+1, when the stage was EMPTY or ONE with a simultaneous pop.
- Ordering is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- out_* fields hold their last value while out_valid = 0. The write-back block must qualify them with out_valid.
- flush:
  - Next state is EMPTY; in_ready becomes 1.
  - A handshake presented in the same cycle is discarded and not counted.
  - flush has priority over every other event.
  - out_count is unaffected by flush.
- out_count increments by 1 on each Pop.
- Reset values (reset_n = 0): state EMPTY; in_ready = 1; out_valid = 0; out_data = 0; out_dest = 0; out_zr = 0; out_ng = 0; out_count = 0; skid contents = 0.
- Reset asserted mid-transfer clears everything asynchronously. No partial entry survives, and the count restarts at 0.
- X on in_data or in_dest while in_valid = 0 must not propagate to any output.

Test Plan:
- Reset, then in_data = 0x0000, dest = 3'b010, in_valid pulse with out_ready = 1 -> next cycle out_valid = 1, out_data = 0x0000, out_zr = 1, out_ng = 0, out_dest = 3'b010; out_count = 1 after the pop edge.
- Stream 0x8000, 0x7FFF, 0xFFFF back-to-back with out_ready held 1 -> one result per cycle in order; flags (zr,ng) = (0,1), (0,0), (0,1); in_ready stays 1 throughout.
- out_ready = 0; send 0x1234 then 0x5678 -> in_ready drops to 0 after the second accept; third value 0xABCD is held off. Raise out_ready -> outputs 0x1234, 0x5678, 0xABCD in order with no loss; out_count = 3.
- In state TWO, assert flush together with in_valid (0x0F0F) and out_ready -> next cycle out_valid = 0, in_ready = 1; 0x0F0F is never output; out_count is unchanged.
- Drop reset_n asynchronously (mid-cycle) while in state TWO with out_count = 5 -> all outputs immediately return to their reset values (out_valid = 0, in_ready = 1, out_count = 0); after release, the first accepted value is the first one output.
- Random in_valid/out_ready at 50% each for 10k cycles against a reference FIFO model -> order and flags match; in_ready is never high in TWO; out_count equals the number of pops mod 65536.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered result stage after the Hack ALU: captures result + destination, derives zr/ng,
// and hands entries to write-back through a 2-entry skid buffer with a registered in_ready.
module alu_result_stage #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEST_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_zr,
  output logic              out_ng,
  output logic [15:0]       out_count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0]  data;
    logic [DEST_W-1:0] dest;
    logic              zr;
    logic              ng;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, skid_q, in_entry;
  logic   in_ready_q, out_valid_q;
  logic [15:0] count_q;

  logic accept, pop;
  logic load_main_in, load_main_skid, load_skid;

  assign accept = in_valid & in_ready_q & ~flush;
  assign pop    = out_valid_q & out_ready & ~flush;

  // Flags are frozen with the entry so the output side never recomputes them.
  always_comb begin
    in_entry.data = in_data;
    in_entry.dest = in_dest;
    in_entry.zr   = ~|in_data;
    in_entry.ng   = in_data[WIDTH-1];
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = StTwo;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (pop) begin
            load_main_skid = 1'b1;
            state_d        = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != StTwo);
      out_valid_q <= (state_d != StEmpty);
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
      if (pop) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q.data;
  assign out_dest  = main_q.dest;
  assign out_zr    = main_q.zr;
  assign out_ng    = main_q.ng;
  assign out_count = count_q;

`ifndef SYNTHESIS
  ready_matches_state: assert property (@(posedge clk) disable iff (!reset_n)
    in_ready_q == (state_q != StTwo));
  valid_matches_state: assert property (@(posedge clk) disable iff (!reset_n)
    out_valid_q == (state_q != StEmpty));
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks of alu_result_stage against hand-computed values and a
// small reference FIFO model.
module tb_alu_result_stage;

  localparam int W = 16;
  localparam int D = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [D-1:0] in_dest;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [D-1:0] out_dest;
  logic         out_zr;
  logic         out_ng;
  logic [15:0]  out_count;

  int n_checks = 0;
  int n_errors = 0;

  alu_result_stage #(
    .WIDTH (W),
    .DEST_W(D)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dest  (in_dest),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_dest (out_dest),
    .out_zr   (out_zr),
    .out_ng   (out_ng),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  logic [W-1:0] stream_v [3];
  logic [1:0]   stream_f [3];
  logic [W+D-1:0] mq[$];
  logic [15:0]  cnt_m;
  logic [W+D-1:0] head;
  logic         vin, rdy, fl, acc, pp;
  logic [W-1:0] rd;
  logic [D-1:0] rdest;

  initial begin
    stream_v = '{16'h8000, 16'h7FFF, 16'hFFFF};
    stream_f = '{2'b01, 2'b00, 2'b01};  // {zr, ng}
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_dest   = '0;
    step();
    step();

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_dest", out_dest, 0);
    check("rst_flags", {out_zr, out_ng}, 0);
    check("rst_count", out_count, 0);
    reset_n = 1'b1;
    step();

    // Single zero result
    in_valid = 1'b1; in_data = 16'h0000; in_dest = 3'b010; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("zero_valid", out_valid, 1);
    check("zero_data", out_data, 16'h0000);
    check("zero_flags", {out_zr, out_ng}, 2'b10);
    check("zero_dest", out_dest, 3'b010);
    step();
    check("zero_count", out_count, 1);
    check("zero_drained", out_valid, 0);

    // Back-to-back stream with out_ready high
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = stream_v[i]; in_dest = D'(i);
      step();
      check("stream_data", out_data, stream_v[i]);
      check("stream_flags", {out_zr, out_ng}, stream_f[i]);
      check("stream_dest", out_dest, i);
      check("stream_ready", in_ready, 1);
      check("stream_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    check("stream_count", out_count, 4);
    check("stream_drained", out_valid, 0);

    // Backpressure: fill both entries, hold off the third
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; in_dest = 3'b001;
    step();
    check("bp_ready1", in_ready, 1);
    in_data = 16'h5678; in_dest = 3'b100;
    step();
    check("bp_ready2", in_ready, 0);
    check("bp_head", out_data, 16'h1234);
    in_data = 16'hABCD; in_dest = 3'b111;
    step();
    check("bp_held_ready", in_ready, 0);
    check("bp_held_head", out_data, 16'h1234);
    check("bp_held_dest", out_dest, 3'b001);
    out_ready = 1'b1;
    step();
    check("bp_pop1", out_data, 16'h5678);
    check("bp_pop1_dest", out_dest, 3'b100);
    check("bp_ready_back", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_pop2", out_data, 16'hABCD);
    check("bp_pop2_flags", {out_zr, out_ng}, 2'b01);
    step();
    check("bp_count", out_count, 7);
    check("bp_drained", out_valid, 0);

    // Flush while full, with a simultaneous handshake
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h1111; step();
    in_data = 16'h2222; step();
    check("fl_full", in_ready, 0);
    flush = 1'b1; in_data = 16'h0F0F; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ready", in_ready, 1);
    check("fl_count", out_count, 7);
    step();
    check("fl_no_ghost", out_valid, 0);
    check("fl_count2", out_count, 7);

    // Asynchronous reset mid-transfer
    reset_n = 1'b0;
    #1;
    check("ar1_count", out_count, 0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = W'(i + 1); step();
    end
    in_valid = 1'b0;
    step();
    check("ar_count5", out_count, 5);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAAA; step();
    in_data = 16'hBBBB; step();
    in_valid = 1'b0;
    check("ar_full", in_ready, 0);
    #3 reset_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_ready", in_ready, 1);
    check("ar_count", out_count, 0);
    check("ar_data", out_data, 0);
    check("ar_flags", {out_zr, out_ng, out_dest}, 0);
    step();
    reset_n = 1'b1;
    in_valid = 1'b1; in_data = 16'hC0DE; in_dest = 3'b011; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("ar_first_valid", out_valid, 1);
    check("ar_first_data", out_data, 16'hC0DE);
    step();
    check("ar_first_count", out_count, 1);

    // Randomized traffic against a reference FIFO
    sync_reset();
    mq.delete();
    cnt_m = 16'd0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      vin = ($urandom_range(1) == 1);
      rdy = ($urandom_range(1) == 1);
      fl  = ($urandom_range(63) == 0);
      case ($urandom_range(7))
        0:       rd = '0;
        1:       rd = 16'h8000;
        default: rd = W'($urandom);
      endcase
      rdest = D'($urandom);
      in_valid = vin; out_ready = rdy; flush = fl;
      in_data = vin ? rd : 'x;
      in_dest = vin ? rdest : 'x;
      #1;
      check("rnd_ready", in_ready, (mq.size() < 2));
      check("rnd_valid", out_valid, (mq.size() > 0));
      if (mq.size() > 0) begin
        head = mq[0];
        check("rnd_data", out_data, head[W+D-1:D]);
        check("rnd_dest", out_dest, head[D-1:0]);
        check("rnd_flags", {out_zr, out_ng},
              {(head[W+D-1:D] == '0), head[W+D-1]});
      end
      acc = vin && (mq.size() < 2) && !fl;
      pp  = rdy && (mq.size() > 0) && !fl;
      step();
      if (fl) begin
        mq.delete();
      end else begin
        if (pp) begin
          void'(mq.pop_front());
          cnt_m = cnt_m + 16'd1;
        end
        if (acc) mq.push_back({rd, rdest});
      end
      if (cyc % 256 == 0) check("rnd_count", out_count, cnt_m);
    end
    check("rnd_count_final", out_count, cnt_m);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
